// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size codes, FSM states and lane masks.
// Also holds the misalignment helper used when MISALIGN_TRAP_EN is defined.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } lsu_state_e;

    // Reserved size 2'b11 behaves as a word access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] ea_lo);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = ea_lo[0];
            default: mis = (ea_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Pipeline-side request/response bundle and memory-side bus bundle of the load/store unit.
interface lsu_req_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] base;
    logic [31:0] imm32;
    logic [31:0] wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (output req_valid, req_we, req_size, req_unsigned, base, imm32, wdata,
                    input  req_ready, rsp_valid, rsp_rdata, rsp_err);
    modport slave  (input  req_valid, req_we, req_size, req_unsigned, base, imm32, wdata,
                    output req_ready, rsp_valid, rsp_rdata, rsp_err);
endinterface

interface lsu_mem_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
                    input  mem_ack, mem_rdata);
    modport slave  (input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
                    output mem_ack, mem_rdata);
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane logic: store enables/replication and load extract with sign/zero extend.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  ea_lo,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    assign byte_s = rdata[{ea_lo, 3'b000} +: 8];
    assign half_s = rdata[{ea_lo[1], 4'b0000} +: 16];

    // Lane selection for both directions; half accesses only look at ea[1].
    always_comb begin
        be        = BE_WORD;
        wdata_rep = wdata;
        rdata_ext = rdata;
        case (size)
            SZ_BYTE: begin
                be        = BE_BYTE << ea_lo;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = is_unsigned ? {24'h000000, byte_s} : {{24{byte_s[7]}}, byte_s};
            end
            SZ_HALF: begin
                be        = BE_HALF << {ea_lo[1], 1'b0};
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = is_unsigned ? {16'h0000, half_s} : {{16{half_s[15]}}, half_s};
            end
            default: begin
                be        = BE_WORD;
                wdata_rep = wdata;
                rdata_ext = rdata;
            end
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: IDLE -> ACCESS -> RESP with mem_ack timeout.
// Optional MISALIGN_TRAP_EN: misaligned half/word requests respond with an error, no memory access.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic      clk,
    input  logic      rst_n,
    lsu_req_if.slave  req,
    lsu_mem_if.master mem
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    lsu_state_e       state_r;
    logic [CNT_W-1:0] tmo_cnt_r;
    logic             we_r;
    logic [1:0]       size_r;
    logic             uns_r;
    logic [1:0]       ea_lo_r;
    logic             mem_req_r;
    logic             mem_we_r;
    logic [31:0]      mem_addr_r;
    logic [3:0]       mem_be_r;
    logic [31:0]      mem_wdata_r;
    logic             rsp_valid_r;
    logic [31:0]      rsp_rdata_r;
    logic             rsp_err_r;

    logic [31:0] ea_s;
    logic [1:0]  al_size_s;
    logic [1:0]  al_ea_lo_s;
    logic        al_uns_s;
    logic [3:0]  al_be_s;
    logic [31:0] al_wdata_s;
    logic [31:0] al_rdata_s;

    assign ea_s = req.base + req.imm32;

    // Aligner sees the incoming request while idle, the captured request otherwise.
    always_comb begin
        al_size_s  = size_r;
        al_ea_lo_s = ea_lo_r;
        al_uns_s   = uns_r;
        if (state_r == ST_IDLE) begin
            al_size_s  = req.req_size;
            al_ea_lo_s = ea_s[1:0];
            al_uns_s   = req.req_unsigned;
        end else begin
            al_size_s  = size_r;
            al_ea_lo_s = ea_lo_r;
            al_uns_s   = uns_r;
        end
    end

    lsu_lane_align u_align (
        .size        (al_size_s),
        .ea_lo       (al_ea_lo_s),
        .is_unsigned (al_uns_s),
        .wdata       (req.wdata),
        .rdata       (mem.mem_rdata),
        .be          (al_be_s),
        .wdata_rep   (al_wdata_s),
        .rdata_ext   (al_rdata_s)
    );

    // Request FSM with registered memory-bus and response outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            tmo_cnt_r   <= '0;
            we_r        <= 1'b0;
            size_r      <= SZ_BYTE;
            uns_r       <= 1'b0;
            ea_lo_r     <= 2'b00;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 32'h0000_0000;
            mem_be_r    <= 4'b0000;
            mem_wdata_r <= 32'h0000_0000;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
            rsp_err_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req.req_valid) begin
`ifdef MISALIGN_TRAP_EN
                        if (is_misaligned(req.req_size, ea_s[1:0])) begin
                            state_r     <= ST_RESP;
                            rsp_valid_r <= 1'b1;
                            rsp_err_r   <= 1'b1;
                            rsp_rdata_r <= 32'h0000_0000;
                        end else begin
`else
                        begin
`endif
                            state_r     <= ST_ACCESS;
                            tmo_cnt_r   <= '0;
                            we_r        <= req.req_we;
                            size_r      <= req.req_size;
                            uns_r       <= req.req_unsigned;
                            ea_lo_r     <= ea_s[1:0];
                            mem_req_r   <= 1'b1;
                            mem_we_r    <= req.req_we;
                            mem_addr_r  <= {ea_s[31:2], 2'b00};
                            mem_be_r    <= al_be_s;
                            mem_wdata_r <= al_wdata_s;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (mem.mem_ack) begin
                        state_r     <= ST_RESP;
                        mem_req_r   <= 1'b0;
                        rsp_valid_r <= 1'b1;
                        rsp_err_r   <= 1'b0;
                        rsp_rdata_r <= we_r ? 32'h0000_0000 : al_rdata_s;
                    end else if ((TIMEOUT != 0) && (tmo_cnt_r == TMO_LIMIT)) begin
                        state_r     <= ST_RESP;
                        mem_req_r   <= 1'b0;
                        rsp_valid_r <= 1'b1;
                        rsp_err_r   <= 1'b1;
                        rsp_rdata_r <= 32'h0000_0000;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    state_r     <= ST_IDLE;
                    rsp_valid_r <= 1'b0;
                    rsp_err_r   <= 1'b0;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    mem_req_r   <= 1'b0;
                    rsp_valid_r <= 1'b0;
                    rsp_err_r   <= 1'b0;
                end
            endcase
        end
    end

    assign req.req_ready = (state_r == ST_IDLE);
    assign req.rsp_valid = rsp_valid_r;
    assign req.rsp_rdata = rsp_rdata_r;
    assign req.rsp_err   = rsp_err_r;
    assign mem.mem_req   = mem_req_r;
    assign mem.mem_we    = mem_we_r;
    assign mem.mem_addr  = mem_addr_r;
    assign mem.mem_be    = mem_be_r;
    assign mem.mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed self-checking bench for lsu_ctrl: alignment, extension, timeout, misalign and reset abort.
module tb_lsu_ctrl;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_pass;
    int   n_req_cycles;
    logic saw_rsp;

    lsu_req_if req_if ();
    lsu_mem_if mem_if ();

    lsu_ctrl #(.TIMEOUT(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req_if),
        .mem   (mem_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Present a request at the falling edge and hold it across one rising edge.
    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] b, input logic [31:0] imm, input logic [31:0] wd);
        @(negedge clk);
        req_if.req_valid    = 1'b1;
        req_if.req_we       = we;
        req_if.req_size     = size;
        req_if.req_unsigned = uns;
        req_if.base         = b;
        req_if.imm32        = imm;
        req_if.wdata        = wd;
        @(posedge clk);
        #1;
        req_if.req_valid = 1'b0;
    endtask

    // Ack at the current falling edge, then sample the response cycle and the return to idle.
    task automatic ack_and_rsp(input string tag, input logic [31:0] rd,
                               input logic [31:0] exp_rd, input logic exp_err);
        mem_if.mem_ack   = 1'b1;
        mem_if.mem_rdata = rd;
        @(posedge clk);
        #1;
        mem_if.mem_ack = 1'b0;
        @(negedge clk);
        chk({tag, "_rsp_valid"}, {31'h0, req_if.rsp_valid}, 32'h1);
        chk({tag, "_rsp_rdata"}, req_if.rsp_rdata, exp_rd);
        chk({tag, "_rsp_err"}, {31'h0, req_if.rsp_err}, {31'h0, exp_err});
        chk({tag, "_resp_ready"}, {31'h0, req_if.req_ready}, 32'h0);
        chk({tag, "_req_drop"}, {31'h0, mem_if.mem_req}, 32'h0);
        @(negedge clk);
        chk({tag, "_rsp_pulse"}, {31'h0, req_if.rsp_valid}, 32'h0);
        chk({tag, "_idle_ready"}, {31'h0, req_if.req_ready}, 32'h1);
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst_n   = 1'b0;
        req_if.req_valid    = 1'b0;
        req_if.req_we       = 1'b0;
        req_if.req_size     = 2'b00;
        req_if.req_unsigned = 1'b0;
        req_if.base         = 32'h0;
        req_if.imm32        = 32'h0;
        req_if.wdata        = 32'h0;
        mem_if.mem_ack      = 1'b0;
        mem_if.mem_rdata    = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'h0, req_if.req_ready}, 32'h1);
        chk("rst_mem_req", {31'h0, mem_if.mem_req}, 32'h0);
        chk("rst_rsp_valid", {31'h0, req_if.rsp_valid}, 32'h0);
        chk("rst_mem_addr", mem_if.mem_addr, 32'h0);
        chk("rst_mem_be", {28'h0, mem_if.mem_be}, 32'h0);
        chk("rst_rsp_rdata", req_if.rsp_rdata, 32'h0);
        rst_n = 1'b1;

        // lw with wrapping effective address, ack on first access cycle
        issue(1'b0, 2'b10, 1'b0, 32'h0000_1000, 32'hFFFF_FFFC, 32'h0);
        @(negedge clk);
        chk("lw_mem_req", {31'h0, mem_if.mem_req}, 32'h1);
        chk("lw_addr", mem_if.mem_addr, 32'h0000_0FFC);
        chk("lw_be", {28'h0, mem_if.mem_be}, 32'hF);
        chk("lw_we", {31'h0, mem_if.mem_we}, 32'h0);
        chk("lw_busy", {31'h0, req_if.req_ready}, 32'h0);
        ack_and_rsp("lw", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);

        // lb at lane 3, one wait cycle; a second request during ACCESS must be ignored
        issue(1'b0, 2'b00, 1'b0, 32'h0000_2000, 32'h0000_0003, 32'h0);
        @(negedge clk);
        chk("lb_be", {28'h0, mem_if.mem_be}, 32'h8);
        req_if.req_valid = 1'b1;
        req_if.base      = 32'h0000_5000;
        @(negedge clk);
        req_if.req_valid = 1'b0;
        chk("lb_addr_stable", mem_if.mem_addr, 32'h0000_2000);
        chk("lb_req_held", {31'h0, mem_if.mem_req}, 32'h1);
        ack_and_rsp("lb", 32'h8011_2233, 32'hFFFF_FF80, 1'b0);

        issue(1'b0, 2'b00, 1'b1, 32'h0000_2000, 32'h0000_0003, 32'h0);
        @(negedge clk);
        ack_and_rsp("lbu", 32'h8011_2233, 32'h0000_0080, 1'b0);

        // sh at upper half
        issue(1'b1, 2'b01, 1'b0, 32'h0000_2000, 32'h0000_0002, 32'h1234_ABCD);
        @(negedge clk);
        chk("sh_be", {28'h0, mem_if.mem_be}, 32'hC);
        chk("sh_wdata", mem_if.mem_wdata, 32'hABCD_ABCD);
        chk("sh_we", {31'h0, mem_if.mem_we}, 32'h1);
        ack_and_rsp("sh", 32'hFFFF_FFFF, 32'h0, 1'b0);

        issue(1'b0, 2'b01, 1'b0, 32'h0000_2000, 32'h0000_0002, 32'h0);
        @(negedge clk);
        ack_and_rsp("lh", 32'h8011_2233, 32'hFFFF_8011, 1'b0);

        issue(1'b0, 2'b01, 1'b1, 32'h0000_2000, 32'h0000_0000, 32'h0);
        @(negedge clk);
        chk("lhu_be", {28'h0, mem_if.mem_be}, 32'h3);
        ack_and_rsp("lhu", 32'h8011_A233, 32'h0000_A233, 1'b0);

        issue(1'b1, 2'b00, 1'b0, 32'h0000_2000, 32'h0000_0001, 32'h7766_555A);
        @(negedge clk);
        chk("sb_be", {28'h0, mem_if.mem_be}, 32'h2);
        chk("sb_wdata", mem_if.mem_wdata, 32'h5A5A_5A5A);
        ack_and_rsp("sb", 32'h0, 32'h0, 1'b0);

        // mem_ack while idle is ignored
        @(negedge clk);
        mem_if.mem_ack = 1'b1;
        @(negedge clk);
        mem_if.mem_ack = 1'b0;
        chk("idle_ack_rsp", {31'h0, req_if.rsp_valid}, 32'h0);

        // Timeout: no ack, request stays up for TIMEOUT cycles then errors
        issue(1'b0, 2'b10, 1'b0, 32'h0000_3000, 32'h0, 32'h0);
        n_req_cycles = 0;
        saw_rsp      = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (req_if.rsp_valid) begin
                saw_rsp = 1'b1;
                break;
            end
            if (mem_if.mem_req) n_req_cycles++;
        end
        chk("tmo_seen", {31'h0, saw_rsp}, 32'h1);
        chk("tmo_req_cycles", n_req_cycles, 32'd16);
        chk("tmo_err", {31'h0, req_if.rsp_err}, 32'h1);
        chk("tmo_rdata", req_if.rsp_rdata, 32'h0);
        chk("tmo_req_drop", {31'h0, mem_if.mem_req}, 32'h0);
        @(negedge clk);

        // Ack arriving on the limit cycle wins over the timeout
        issue(1'b0, 2'b10, 1'b0, 32'h0000_3000, 32'h0, 32'h0);
        repeat (16) @(negedge clk);
        chk("lim_req_still", {31'h0, mem_if.mem_req}, 32'h1);
        ack_and_rsp("lim", 32'h1357_9BDF, 32'h1357_9BDF, 1'b0);

        // Misaligned word
        issue(1'b0, 2'b10, 1'b0, 32'h0000_2000, 32'h0000_0001, 32'h0);
        @(negedge clk);
`ifdef MISALIGN_TRAP_EN
        chk("mis_no_req", {31'h0, mem_if.mem_req}, 32'h0);
        chk("mis_rsp_valid", {31'h0, req_if.rsp_valid}, 32'h1);
        chk("mis_err", {31'h0, req_if.rsp_err}, 32'h1);
        chk("mis_rdata", req_if.rsp_rdata, 32'h0);
        @(negedge clk);
`else
        chk("mis_addr", mem_if.mem_addr, 32'h0000_2000);
        chk("mis_be", {28'h0, mem_if.mem_be}, 32'hF);
        ack_and_rsp("mis", 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0);
`endif

        // Reset during ACCESS abandons the transaction
        issue(1'b0, 2'b10, 1'b0, 32'h0000_4000, 32'h0, 32'h0);
        @(negedge clk);
        chk("rabt_req_up", {31'h0, mem_if.mem_req}, 32'h1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rabt_req_drop", {31'h0, mem_if.mem_req}, 32'h0);
        chk("rabt_ready", {31'h0, req_if.req_ready}, 32'h1);
        rst_n = 1'b1;
        mem_if.mem_ack = 1'b1;
        saw_rsp = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (req_if.rsp_valid) saw_rsp = 1'b1;
        end
        mem_if.mem_ack = 1'b0;
        chk("rabt_no_rsp", {31'h0, saw_rsp}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
